dice_display_scan_ctrl: RTL

Time-multiplexes the two-digit common-electrode 7-segment display of the dice design. Takes BCD digits from the roll/I2C logic and double-buffers them so a digit pair only changes at a frame boundary. Sequences the ones and tens commons with dead-time blanking between slots. Applies the segment and common polarities configured on uio_in[7:6].

---
 rtl/dice_display_scan_ctrl_if.sv | 10 +
 rtl/dice_display_scan_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dice_display_scan_ctrl_if.sv
// Digit update bus between the roll/I2C logic (master) and the display
// scanner (slave): a BCD digit pair plus a one-cycle capture strobe.
interface dice_display_scan_ctrl_if;
  logic [3:0] digit1_in;
  logic [3:0] digit10_in;
  logic       upd;

  modport master (output digit1_in, output digit10_in, output upd);
  modport slave  (input  digit1_in, input  digit10_in, input  upd);
endinterface

// File: rtl/dice_display_scan_ctrl.sv
// Two-digit multiplexed 7-segment scanner with dead-time blanking and a
// frame-synchronous double-buffered digit pair.
module dice_display_scan_ctrl #(
  parameter int SCAN_DIV = 1024,
  parameter int DEAD     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  dice_display_scan_ctrl_if.slave   dig,
  input  logic                      com_pol,
  input  logic                      seg_pol,
  input  logic                      blank_lz,
  output logic [7:0]                seg_out,
  output logic [1:0]                com_out,
  output logic [1:0]                com_oe,
  output logic                      frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - DEAD - 1);

  typedef enum logic [1:0] {DEAD0, ONES, DEAD1, TENS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lit_q, lit_d;
  logic [1:0]    act_q, act_d;
  logic          oe_q, oe_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    pend1_q, pend1_d, pend10_q, pend10_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    sh1_q, sh1_d, sh10_q, sh10_d;
  logic          last, boundary;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'h3F;
      4'd1:    decode = 8'h06;
      4'd2:    decode = 8'h5B;
      4'd3:    decode = 8'h4F;
      4'd4:    decode = 8'h66;
      4'd5:    decode = 8'h6D;
      4'd6:    decode = 8'h7D;
      4'd7:    decode = 8'h07;
      4'd8:    decode = 8'h7F;
      4'd9:    decode = 8'h6F;
      4'd15:   decode = 8'h00;
      default: decode = 8'h40;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    lit_d        = 8'h00;
    act_d        = 2'b00;
    oe_d         = ena;
    pend1_d      = pend1_q;
    pend10_d     = pend10_q;
    pend_v_d     = pend_v_q;
    sh1_d        = sh1_q;
    sh10_d       = sh10_q;

    last     = (state_q == ONES || state_q == TENS) ? (cnt_q == SLOT_LAST)
                                                    : (cnt_q == DEAD_LAST);
    boundary = ena && state_q == TENS && last;

    if (last) begin
      cnt_d = '0;
      case (state_q)
        DEAD0:   state_d = ONES;
        ONES:    state_d = DEAD1;
        DEAD1:   state_d = TENS;
        default: state_d = DEAD0;
      endcase
    end

    // A blank digit keeps its common off as well, so an empty display draws nothing.
    case (state_q)
      ONES: if (sh1_q != 4'hF) begin
        lit_d = decode(sh1_q);
        act_d = 2'b01;
      end
      TENS: if (sh10_q != 4'hF && !(blank_lz && sh10_q == 4'd0)) begin
        lit_d = decode(sh10_q);
        act_d = 2'b10;
      end
      default: ;
    endcase

    if (dig.upd) begin
      pend1_d  = dig.digit1_in;
      pend10_d = dig.digit10_in;
      pend_v_d = 1'b1;
    end

    // An update arriving on the boundary itself bypasses the pending pair.
    if (boundary) begin
      if (dig.upd) begin
        sh1_d  = dig.digit1_in;
        sh10_d = dig.digit10_in;
      end else if (pend_v_q) begin
        sh1_d  = pend1_q;
        sh10_d = pend10_q;
      end
      pend_v_d = 1'b0;
    end

    if (!ena) begin
      state_d = DEAD0;
      cnt_d   = '0;
      lit_d   = 8'h00;
      act_d   = 2'b00;
    end

    // Looks one state ahead so the pulse sits on the boundary cycle itself.
    frame_done_d = ena && state_d == TENS && cnt_d == SLOT_LAST;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= DEAD0;
      cnt_q        <= '0;
      lit_q        <= 8'h00;
      act_q        <= 2'b00;
      oe_q         <= 1'b0;
      frame_done_q <= 1'b0;
      pend1_q      <= 4'h0;
      pend10_q     <= 4'h0;
      pend_v_q     <= 1'b0;
      sh1_q        <= 4'hF;
      sh10_q       <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lit_q        <= lit_d;
      act_q        <= act_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
      pend1_q      <= pend1_d;
      pend10_q     <= pend10_d;
      pend_v_q     <= pend_v_d;
      sh1_q        <= sh1_d;
      sh10_q       <= sh10_d;
    end
  end

  assign seg_out    = seg_pol ? lit_q : ~lit_q;
  assign com_out[0] = act_q[0] ? com_pol : ~com_pol;
  assign com_out[1] = act_q[1] ? com_pol : ~com_pol;
  assign com_oe     = {2{oe_q}};
  assign frame_done = frame_done_q;

endmodule
